load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding bus access, byte-lane masking, load extension, 8-bit bus watchdog.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned half/word accesses instead of force-aligning them.
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_mem_wren,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  input  logic [1:0]  i_s_length,
  input  logic [2:0]  i_l_length,
  input  logic        i_l_unsigned,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_ld_data,
  output logic        o_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_bmask,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);
  localparam int NUM_LANES = 4;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        uns;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_d, req_q;
  logic [7:0]  wd;
  logic [31:0] ld_q, ld_ext;
  logic        err_q, misal, busy;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [NUM_LANES-1:0][7:0] lane_wdata;

  // Normalise the request to a 2-bit size; anything unlisted becomes a word access.
  always_comb begin
    req_d.we   = i_mem_wren;
    req_d.addr = i_addr;
    req_d.data = i_st_data;
    req_d.uns  = i_l_unsigned;
    req_d.size = SZ_W;
    if (i_mem_wren) begin
      if (i_s_length != 2'b11) req_d.size = i_s_length;
    end else begin
      case (i_l_length)
        3'b000: req_d.size = SZ_B;
        3'b001: req_d.size = SZ_H;
        3'b100: begin req_d.size = SZ_B; req_d.uns = 1'b1; end
        3'b101: begin req_d.size = SZ_H; req_d.uns = 1'b1; end
        default: req_d.size = SZ_W;
      endcase
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign misal = (req_d.size == SZ_H && i_addr[0]) ||
                 (req_d.size == SZ_W && i_addr[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req) state_nxt = misal ? DONE : WAIT;
      WAIT:    if (i_mem_ack || wd == 8'd254) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ld_b = i_mem_rdata[{req_q.addr[1:0], 3'b000} +: 8];
  assign ld_h = req_q.addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    ld_ext = i_mem_rdata;
    case (req_q.size)
      SZ_B:    ld_ext = req_q.uns ? {24'h0, ld_b} : {{24{ld_b[7]}}, ld_b};
      SZ_H:    ld_ext = req_q.uns ? {16'h0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld_ext = i_mem_rdata;
    endcase
  end

  // Watchdog wd counts completed WAIT cycles; the 255th without ack times out.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      req_q <= '0;
      wd    <= 8'd0;
      ld_q  <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (i_req) begin
          req_q <= req_d;
          wd    <= 8'd0;
          ld_q  <= 32'd0;
          err_q <= misal;
        end
        WAIT: begin
          wd <= wd + 8'd1;
          if (i_mem_ack) begin
            ld_q  <= req_q.we ? 32'd0 : ld_ext;
            err_q <= 1'b0;
          end else if (wd == 8'd254) begin
            ld_q  <= 32'd0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_wdata[i] = (req_q.size == SZ_B) ? req_q.data[7:0] :
                           (req_q.size == SZ_H) ? req_q.data[8*(i%2) +: 8] :
                                                  req_q.data[8*i +: 8];
  end

  assign busy        = (state == WAIT);
  assign o_stall     = busy || (state == IDLE && i_req);
  assign o_done      = (state == DONE);
  assign o_ld_data   = o_done ? ld_q : 32'd0;
  assign o_err       = o_done && err_q;
  assign o_mem_req   = busy;
  assign o_mem_we    = busy && req_q.we;
  assign o_mem_addr  = busy ? {req_q.addr[31:2], 2'b00} : 32'd0;
  assign o_mem_wdata = busy ? lane_wdata : 32'd0;

  always_comb begin
    o_mem_bmask = 4'b0000;
    if (busy) begin
      case (req_q.size)
        SZ_B:    o_mem_bmask = 4'b0001 << req_q.addr[1:0];
        SZ_H:    o_mem_bmask = req_q.addr[1] ? 4'b1100 : 4'b0011;
        default: o_mem_bmask = 4'b1111;
      endcase
    end
  end
endmodule
